// File: rtl/life_row_if.sv
// Control, scan and status bundle for one life_row engine.
// The master drives load/scan/step controls; the slave is the row engine itself.
interface life_row_if #(
    parameter int WIDTH = 16,
    parameter int GEN_W = 16
);
    localparam int POP_W = $clog2(WIDTH + 1);

    logic             enb;
    logic             write;
    logic [WIDTH-1:0] wr_data;
    logic             scan_en;
    logic             scan_in;
    logic             scan_out;
    logic [WIDTH-1:0] alive;
    logic [WIDTH-1:0] alive_prev;
    logic             stable;
    logic             cycle_det;
    logic [GEN_W-1:0] gen_count;
    logic [POP_W-1:0] pop_count;

    modport master (
        output enb, write, wr_data, scan_en, scan_in,
        input  scan_out, alive, alive_prev, stable, cycle_det, gen_count, pop_count
    );

    modport slave (
        input  enb, write, wr_data, scan_en, scan_in,
        output scan_out, alive, alive_prev, stable, cycle_det, gen_count, pop_count
    );
endinterface

// File: rtl/life_row.sv
// Row-parallel cellular automaton: WIDTH cells stepped together under a programmable B/S rule,
// with history, stable/cycle flags and a scan chain. Optional population counter: LIFE_ROW_POPCOUNT_EN.
module life_row #(
    parameter int WIDTH      = 16,
    parameter int HIST_DEPTH = 2,
    parameter int WRAP       = 1,
    parameter int GEN_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] north_row,
    input  logic [WIDTH-1:0] south_row,
    input  logic [2:0]       west_col,
    input  logic [2:0]       east_col,
    input  logic [8:0]       birth_mask,
    input  logic [8:0]       survive_mask,
    life_row_if.slave        bus
);
    localparam int POP_W = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] alive_q;
    logic [WIDTH-1:0] hist_q [HIST_DEPTH];
    logic             stable_q;
    logic             cycle_q;
    logic [GEN_W-1:0] gen_q;

    logic [WIDTH+1:0] n_ext;
    logic [WIDTH+1:0] o_ext;
    logic [WIDTH+1:0] s_ext;
    logic [WIDTH-1:0] next_row;
    logic [3:0]       cnt;
    logic             stable_d;
    logic             cycle_d;

    // Rows extended by one column each side: bit 0 is column -1, bit WIDTH+1 is column WIDTH.
    assign n_ext = {(WRAP != 0) ? north_row[0] : east_col[2], north_row,
                    (WRAP != 0) ? north_row[WIDTH-1] : west_col[2]};
    assign o_ext = {(WRAP != 0) ? alive_q[0] : east_col[1], alive_q,
                    (WRAP != 0) ? alive_q[WIDTH-1] : west_col[1]};
    assign s_ext = {(WRAP != 0) ? south_row[0] : east_col[0], south_row,
                    (WRAP != 0) ? south_row[WIDTH-1] : west_col[0]};

    // NOTE: every variable written here gets a default first so no latch is inferred.
    always_comb begin
        next_row = '0;
        cnt      = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt = 4'(n_ext[i]) + 4'(n_ext[i+1]) + 4'(n_ext[i+2])
                + 4'(o_ext[i]) + 4'(o_ext[i+2])
                + 4'(s_ext[i]) + 4'(s_ext[i+1]) + 4'(s_ext[i+2]);
            next_row[i] = alive_q[i] ? survive_mask[cnt] : birth_mask[cnt];
        end
    end

    assign stable_d = (next_row == alive_q);
    assign cycle_d  = (next_row == hist_q[HIST_DEPTH-1]) && !stable_d;

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            alive_q  <= '0;
            // NOTE: the history is a handful of flops, not a RAM, so clearing it on reset is cheap and required.
            for (int k = 0; k < HIST_DEPTH; k++) hist_q[k] <= '0;
            stable_q <= 1'b0;
            cycle_q  <= 1'b0;
            gen_q    <= '0;
        end else if (bus.write) begin
            alive_q  <= bus.wr_data;
            for (int k = 0; k < HIST_DEPTH; k++) hist_q[k] <= bus.wr_data;
            stable_q <= 1'b0;
            cycle_q  <= 1'b0;
            gen_q    <= '0;
        end else if (bus.scan_en) begin
            alive_q <= {bus.scan_in, alive_q[WIDTH-1:1]};
        end else if (bus.enb) begin
            alive_q   <= next_row;
            hist_q[0] <= alive_q;
            for (int k = 1; k < HIST_DEPTH; k++) hist_q[k] <= hist_q[k-1];
            stable_q  <= stable_d;
            cycle_q   <= cycle_d;
            gen_q     <= gen_q + GEN_W'(1);
        end
    end

`ifdef LIFE_ROW_POPCOUNT_EN
    logic [POP_W-1:0] pop_sum;
    logic [POP_W-1:0] pop_q;

    always_comb begin
        pop_sum = '0;
        for (int i = 0; i < WIDTH; i++) pop_sum = pop_sum + POP_W'(alive_q[i]);
    end

    // Registered from alive_q, so it trails any change of the row by one cycle.
    always_ff @(posedge clk) begin
        if (reset) pop_q <= '0;
        else       pop_q <= pop_sum;
    end

    assign bus.pop_count = pop_q;
`else
    assign bus.pop_count = '0;
`endif

    assign bus.alive      = alive_q;
    assign bus.alive_prev = hist_q[0];
    assign bus.scan_out   = alive_q[0];
    assign bus.stable     = stable_q;
    assign bus.cycle_det  = cycle_q;
    assign bus.gen_count  = gen_q;
endmodule

// File: tb/tb_life_row.sv
// Directed bench for life_row: an 8-cell torus instance plus an 8-cell edge-column instance
// with a 3-bit generation counter, checked with immediate assertions.
module tb_life_row;
    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] north_row;
    logic [7:0] south_row;
    logic [2:0] west_col;
    logic [2:0] east_col;
    logic [8:0] birth_mask;
    logic [8:0] survive_mask;

    int n_cmp = 0;
    int n_mis = 0;

`ifdef LIFE_ROW_POPCOUNT_EN
    localparam int POP_F0 = 4;
`else
    localparam int POP_F0 = 0;
`endif

    life_row_if #(.WIDTH(8), .GEN_W(16)) bus_w ();
    life_row_if #(.WIDTH(8), .GEN_W(3))  bus_nw ();

    life_row #(.WIDTH(8), .HIST_DEPTH(2), .WRAP(1), .GEN_W(16)) u_dut (
        .clk(clk), .reset(reset),
        .north_row(north_row), .south_row(south_row),
        .west_col(west_col), .east_col(east_col),
        .birth_mask(birth_mask), .survive_mask(survive_mask),
        .bus(bus_w)
    );

    life_row #(.WIDTH(8), .HIST_DEPTH(2), .WRAP(0), .GEN_W(3)) u_dut_nw (
        .clk(clk), .reset(reset),
        .north_row(north_row), .south_row(south_row),
        .west_col(west_col), .east_col(east_col),
        .birth_mask(birth_mask), .survive_mask(survive_mask),
        .bus(bus_nw)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_w();
        bus_w.enb = 1'b0; bus_w.write = 1'b0; bus_w.scan_en = 1'b0; bus_w.scan_in = 1'b0;
    endtask

    task automatic idle_nw();
        bus_nw.enb = 1'b0; bus_nw.write = 1'b0; bus_nw.scan_en = 1'b0; bus_nw.scan_in = 1'b0;
    endtask

    initial begin
        logic [7:0] seq;
        seq          = 8'h8D;  // bit k is the k-th scan_in value: 1,0,1,1,0,0,0,1
        north_row    = '0; south_row = '0; west_col = '0; east_col = '0;
        birth_mask   = 9'h008; survive_mask = 9'h00C;
        bus_w.wr_data = '0; bus_nw.wr_data = '0;
        idle_w(); idle_nw();

        reset = 1'b1; tick(); tick(); reset = 1'b0;
        check("rst_alive", 32'(bus_w.alive), 32'h00);
        check("rst_prev",  32'(bus_w.alive_prev), 32'h00);
        check("rst_gen",   32'(bus_w.gen_count), 32'h0);
        check("rst_flags", {30'b0, bus_w.stable, bus_w.cycle_det}, 32'h0);
        check("rst_pop",   32'(bus_w.pop_count), 32'h0);

        // 3x3 block between fixed rows: centre column over-crowded, cells 1 and 5 born
        north_row = 8'h1C; south_row = 8'h1C;
        bus_w.write = 1'b1; bus_w.wr_data = 8'h1C; tick(); idle_w();
        bus_w.enb = 1'b1; tick(); idle_w();
        check("blk_alive",  32'(bus_w.alive), 32'h22);
        check("blk_stable", 32'(bus_w.stable), 32'h0);
        check("blk_gen",    32'(bus_w.gen_count), 32'h1);
        check("blk_prev",   32'(bus_w.alive_prev), 32'h1C);

        // Isolated blinker row: centre survives, then dies
        north_row = '0; south_row = '0;
        bus_w.write = 1'b1; bus_w.wr_data = 8'h1C; tick(); idle_w();
        check("wr_gen", 32'(bus_w.gen_count), 32'h0);
        bus_w.enb = 1'b1; tick(); idle_w();
        check("bl1_alive",  32'(bus_w.alive), 32'h08);
        check("bl1_stable", 32'(bus_w.stable), 32'h0);
        bus_w.enb = 1'b1; tick(); idle_w();
        check("bl2_alive", 32'(bus_w.alive), 32'h00);
        check("bl2_cyc",   32'(bus_w.cycle_det), 32'h0);
        bus_w.enb = 1'b1; tick(); idle_w();
        check("bl3_stable", 32'(bus_w.stable), 32'h1);
        check("bl3_gen",    32'(bus_w.gen_count), 32'h3);
        tick();
        check("hold_stable", 32'(bus_w.stable), 32'h1);
        check("hold_gen",    32'(bus_w.gen_count), 32'h3);

        // Population counter trails the row by one cycle
        bus_w.write = 1'b1; bus_w.wr_data = 8'hF0; tick(); idle_w();
        check("pop_lag", 32'(bus_w.pop_count), 32'h0);
        tick();
        check("pop_f0", 32'(bus_w.pop_count), 32'(POP_F0));

        // Corner cells: torus versus zero edge columns
        north_row = 8'h81; south_row = 8'h81; west_col = '0; east_col = '0;
        bus_w.write = 1'b1; bus_w.wr_data = 8'h81;
        bus_nw.write = 1'b1; bus_nw.wr_data = 8'h81; tick(); idle_w(); idle_nw();
        bus_w.enb = 1'b1; bus_nw.enb = 1'b1; tick(); idle_w(); idle_nw();
        check("wrap_alive",   32'(bus_w.alive), 32'h42);
        check("nowrap_alive", 32'(bus_nw.alive), 32'hC3);

        // West edge column alone gives cell 0 three neighbours
        north_row = '0; south_row = '0; west_col = 3'b111;
        bus_nw.write = 1'b1; bus_nw.wr_data = 8'h00; tick(); idle_nw();
        bus_nw.enb = 1'b1; tick(); idle_nw();
        check("west_birth", 32'(bus_nw.alive), 32'h01);
        west_col = '0;
        for (int k = 0; k < 6; k++) begin bus_nw.enb = 1'b1; tick(); end
        idle_nw();
        check("gen_max", 32'(bus_nw.gen_count), 32'h7);
        bus_nw.enb = 1'b1; tick(); idle_nw();
        check("gen_wrap", 32'(bus_nw.gen_count), 32'h0);

        // Scan load with enb held high (ignored), then readout
        bus_w.write = 1'b1; bus_w.wr_data = 8'hA5; tick(); idle_w();
        for (int k = 0; k < 8; k++) begin
            bus_w.scan_en = 1'b1; bus_w.enb = 1'b1; bus_w.scan_in = seq[k]; tick();
        end
        idle_w();
        check("scan_alive", 32'(bus_w.alive), 32'h8D);
        check("scan_prev",  32'(bus_w.alive_prev), 32'hA5);
        check("scan_gen",   32'(bus_w.gen_count), 32'h0);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("scan_out%0d", k), 32'(bus_w.scan_out), 32'(seq[k]));
            bus_w.scan_en = 1'b1; bus_w.scan_in = 1'b0; tick();
        end
        idle_w();
        check("scan_empty", 32'(bus_w.alive), 32'h00);
        check("scan_hist",  32'(bus_w.alive_prev), 32'hA5);

        // Anti-rule: all die, then all born; second step returns to the oldest history entry
        birth_mask = 9'h001; survive_mask = 9'h000;
        bus_w.write = 1'b1; bus_w.wr_data = 8'hFF; tick(); idle_w();
        bus_w.enb = 1'b1; tick(); idle_w();
        check("cyc1_alive", 32'(bus_w.alive), 32'h00);
        check("cyc1_det",   32'(bus_w.cycle_det), 32'h0);
        bus_w.enb = 1'b1; tick(); idle_w();
        check("cyc2_alive", 32'(bus_w.alive), 32'hFF);
        check("cyc2_det",   32'(bus_w.cycle_det), 32'h1);
        check("cyc2_gen",   32'(bus_w.gen_count), 32'h2);

        // reset beats write and enb in the same cycle
        bus_w.write = 1'b1; bus_w.wr_data = 8'h3C; bus_w.enb = 1'b1; reset = 1'b1; tick();
        reset = 1'b0;
        check("pri_alive", 32'(bus_w.alive), 32'h00);
        check("pri_prev",  32'(bus_w.alive_prev), 32'h00);
        check("pri_gen",   32'(bus_w.gen_count), 32'h0);
        check("pri_cyc",   32'(bus_w.cycle_det), 32'h0);
        tick(); idle_w();
        check("pri_wr_alive", 32'(bus_w.alive), 32'h3C);
        check("pri_wr_gen",   32'(bus_w.gen_count), 32'h0);

        // reset mid-scan aborts the shift
        for (int k = 0; k < 3; k++) begin bus_w.scan_en = 1'b1; bus_w.scan_in = 1'b1; tick(); end
        reset = 1'b1; tick(); reset = 1'b0; idle_w();
        check("abort_alive", 32'(bus_w.alive), 32'h00);
        check("abort_pop",   32'(bus_w.pop_count), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
